// File: rtl/key_pkg.sv
// Shared types and default constants for the key debounce bank.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } key_fsm_e;

  localparam int unsigned KEY_NUM_DEF  = 4;
  localparam int unsigned CNT_MAX_DEF  = 999_999;     // 20 ms at 50 MHz
  localparam int unsigned LONG_MAX_DEF = 49_999_999;  // 1 s at 50 MHz

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: synchronizer, debounce FSM, registered press/release strobes.
// Long-press detection is compiled in when KEY_LONG_PRESS_EN is defined.
module key_filter_ch
  import key_pkg::*;
#(
`ifdef KEY_LONG_PRESS_EN
  parameter int unsigned LONG_MAX = LONG_MAX_DEF,
`endif
  parameter int unsigned CNT_MAX  = CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CNT_MAX);

  logic             sync_p0;
  logic             ks;
  key_fsm_e         state_q;
  key_fsm_e         state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_d;
  logic             release_d;
  logic             level_d;

  // Two-flop synchronizer; resets to the released (high) pin level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      ks      <= 1'b1;
    end else begin
      sync_p0 <= key_in;
      ks      <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ks) begin
          state_d = FILT_DN;
          cnt_d   = '0;
        end
      end
      FILT_DN: begin
        if (ks) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (ks) begin
          state_d = FILT_UP;
          cnt_d   = '0;
        end
      end
      FILT_UP: begin
        if (!ks) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Level follows the next state so it switches in the same cycle as the strobe
    level_d = (state_d == DOWN) || (state_d == FILT_UP);
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LONG_W = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;
  localparam logic [LONG_W-1:0] LONG_TC = LONG_W'(LONG_MAX);

  logic [LONG_W-1:0] long_cnt;
  logic              long_done;

  // Restarts only on a fresh press; a FILT_UP bounce back to DOWN keeps counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (press_d) begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else if ((state_q == DOWN) || (state_q == FILT_UP)) begin
        if (long_cnt == LONG_TC) begin
          if (!long_done) begin
            key_long  <= 1'b1;
            long_done <= 1'b1;
          end
        end else begin
          long_cnt <= long_cnt + LONG_W'(1);
        end
      end
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Bank of KEY_NUM independent active-low key debouncers with press/release strobes.
// Optional long-press strobes are built when KEY_LONG_PRESS_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned KEY_NUM  = KEY_NUM_DEF,
`ifdef KEY_LONG_PRESS_EN
  parameter int unsigned LONG_MAX = LONG_MAX_DEF,
`endif
  parameter int unsigned CNT_MAX  = CNT_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_filter_ch #(
`ifdef KEY_LONG_PRESS_EN
      .LONG_MAX (LONG_MAX),
`endif
      .CNT_MAX  (CNT_MAX)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce with CNT_MAX=9, LONG_MAX=49.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] acc_p, acc_r, acc_l;

  always #5 clk = ~clk;

  key_debounce #(
    .KEY_NUM  (4),
`ifdef KEY_LONG_PRESS_EN
    .LONG_MAX (49),
`endif
    .CNT_MAX  (9)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n negedges, OR-accumulating every strobe seen along the way
  task automatic run(input int n, output logic [3:0] p, output logic [3:0] r,
                     output logic [3:0] l);
    p = '0;
    r = '0;
    l = '0;
    repeat (n) begin
      @(negedge clk);
      p |= key_press;
      r |= key_release;
      l |= key_long;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    run(3, acc_p, acc_r, acc_l);
    chk("rst_state",   key_state,   4'b0000);
    chk("rst_press",   key_press,   4'b0000);
    chk("rst_release", key_release, 4'b0000);
    chk("rst_long",    key_long,    4'b0000);
    rst = 1'b1;
    run(3, acc_p, acc_r, acc_l);

    // Clean press on key 0: strobe in the cycle after the 13th edge
    key_in[0] = 1'b0;
    run(12, acc_p, acc_r, acc_l);
    chk("s1_no_early_press", acc_p, 4'b0000);
    chk("s1_state_before",   key_state, 4'b0000);
    @(negedge clk);
    chk("s1_press",   key_press, 4'b0001);
    chk("s1_state",   key_state, 4'b0001);
    @(negedge clk);
    chk("s1_press_end", key_press, 4'b0000);
    chk("s1_state_hold", key_state, 4'b0001);

    // Bounce on key 1: 6 low, 2 high, then stable low
    key_in[1] = 1'b0;
    run(6, acc_p, acc_r, acc_l);
    chk("s2_glitch_lo", acc_p, 4'b0000);
    key_in[1] = 1'b1;
    run(2, acc_p, acc_r, acc_l);
    chk("s2_glitch_hi", acc_p, 4'b0000);
    key_in[1] = 1'b0;
    run(12, acc_p, acc_r, acc_l);
    chk("s2_no_early_press", acc_p, 4'b0000);
    chk("s2_state_before", key_state, 4'b0001);
    @(negedge clk);
    chk("s2_press", key_press, 4'b0010);
    chk("s2_state", key_state, 4'b0011);
    run(5, acc_p, acc_r, acc_l);
    chk("s2_single_press", acc_p, 4'b0000);

    // Release glitch on key 0 (5 cycles) must do nothing
    key_in[0] = 1'b1;
    run(5, acc_p, acc_r, acc_l);
    key_in[0] = 1'b0;
    chk("s3_glitch_rel_a", acc_r, 4'b0000);
    run(20, acc_p, acc_r, acc_l);
    chk("s3_glitch_rel_b", acc_r | acc_p, 4'b0000);
    chk("s3_glitch_state", key_state, 4'b0011);

    // Real release of key 0
    key_in[0] = 1'b1;
    run(12, acc_p, acc_r, acc_l);
    chk("s3_no_early_rel", acc_r, 4'b0000);
    @(negedge clk);
    chk("s3_release", key_release, 4'b0001);
    chk("s3_state",   key_state,   4'b0010);
    @(negedge clk);
    chk("s3_release_end", key_release, 4'b0000);

    // Release key 1, then press all four together
    key_in[1] = 1'b1;
    run(20, acc_p, acc_r, acc_l);
    chk("s4_rel1", acc_r, 4'b0010);
    chk("s4_idle", key_state, 4'b0000);
    key_in = 4'b0000;
    run(12, acc_p, acc_r, acc_l);
    chk("s4_no_early_press", acc_p, 4'b0000);
    @(negedge clk);
    chk("s4_press_all", key_press, 4'b1111);
    chk("s4_state_all", key_state, 4'b1111);
    @(negedge clk);
    chk("s4_press_end", key_press, 4'b0000);

    // Release only key 2
    key_in[2] = 1'b1;
    run(12, acc_p, acc_r, acc_l);
    chk("s4_no_early_rel", acc_r, 4'b0000);
    @(negedge clk);
    chk("s4_release2", key_release, 4'b0100);
    chk("s4_state_1011", key_state, 4'b1011);
    run(5, acc_p, acc_r, acc_l);
    chk("s4_quiet", acc_p | acc_r, 4'b0000);

    // Asynchronous reset while keys 0,1,3 are in DOWN
    #2 rst = 1'b0;
    #1;
    chk("s5_async_state",   key_state,   4'b0000);
    chk("s5_async_release", key_release, 4'b0000);
    run(4, acc_p, acc_r, acc_l);
    chk("s5_in_reset", acc_p | acc_r | acc_l | key_state, 4'b0000);
    rst = 1'b1;
    run(12, acc_p, acc_r, acc_l);
    chk("s5_no_release", acc_r, 4'b0000);
    chk("s5_no_early_press", acc_p, 4'b0000);
    @(negedge clk);
    chk("s5_press", key_press, 4'b1011);
    chk("s5_state", key_state, 4'b1011);

    // Long press: strobe 50 cycles after key_press, once only
`ifdef KEY_LONG_PRESS_EN
    run(49, acc_p, acc_r, acc_l);
    chk("s6_no_early_long", acc_l, 4'b0000);
    @(negedge clk);
    chk("s6_long", key_long, 4'b1011);
    run(40, acc_p, acc_r, acc_l);
    chk("s6_no_repeat", acc_l, 4'b0000);
`else
    run(90, acc_p, acc_r, acc_l);
    chk("s6_long_off", acc_l, 4'b0000);
`endif
    chk("s6_held_state", key_state, 4'b1011);

    key_in = 4'hF;
    run(20, acc_p, acc_r, acc_l);
    chk("end_release", acc_r, 4'b1011);
    chk("end_state", key_state, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
